// File: rtl/spram_arbiter.sv
// spram_arbiter: two-port (capture write / display read) arbiter in front of a
// single-port SPRAM. Arbitration happens every cycle; the winning request is
// registered, so the memory strobes and the matching ack appear one cycle later.
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   wr_req/addr/data     write request, held until wr_ack; wr_ack one-cycle pulse
//   rd_req/addr          read request, held until rd_ack; rd_ack one-cycle pulse
//   rd_valid/rd_data     read result, pulses two cycles after the read grant
//   mem_ad/di/we, mem_do SPRAM interface (mem_do valid one cycle after address)
//   wr_count/_clr        count of in-range writes, synchronous clear
module spram_arbiter #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DEPTH_LIMIT  = 16000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_di,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_do,
  output logic [ADDR_W-1:0] wr_count,
  input  logic              wr_count_clr
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GNT_RD, GNT_WR} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [ADDR_W-1:0]   mem_ad_q;
  logic [DATA_W-1:0]   mem_di_q;
  logic                mem_we_q;
  logic                rd_oor_q;
  logic                rd_valid_q;
  logic                rd_zero_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [ADDR_W-1:0]   wr_count_q;

  logic wr_elig, rd_elig, wr_in_range, rd_in_range, cnt_inc;

  assign wr_in_range = 32'(wr_addr) < DEPTH_LIMIT;
  assign rd_in_range = 32'(rd_addr) < DEPTH_LIMIT;

  // A requester whose ack is showing this cycle sits out one arbitration round.
  assign wr_elig = wr_req && (state_q != GNT_WR);
  assign rd_elig = rd_req && (state_q != GNT_RD);

  always_comb begin
    state_d = IDLE;
    if (wr_elig && (!rd_elig || (starve_q >= STARVE_MAX))) begin
      state_d = GNT_WR;
    end else if (rd_elig) begin
      state_d = GNT_RD;
    end

    starve_d = starve_q;
    if (!wr_req || state_d == GNT_WR) begin
      starve_d = '0;
    end else if (state_q != GNT_WR && starve_q < STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign cnt_inc = (state_d == GNT_WR) && wr_in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      mem_ad_q   <= '0;
      mem_di_q   <= '0;
      mem_we_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
      rd_data_q  <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      mem_we_q   <= cnt_inc;
      rd_oor_q   <= (state_d == GNT_RD) && !rd_in_range;
      rd_valid_q <= (state_q == GNT_RD);
      rd_zero_q  <= rd_oor_q;
      case (state_d)
        GNT_WR: begin
          mem_ad_q <= wr_addr;
          mem_di_q <= wr_data;
        end
        GNT_RD:  mem_ad_q <= rd_in_range ? rd_addr : '0;
        default: ;
      endcase
      if (wr_count_clr) begin
        wr_count_q <= cnt_inc ? ADDR_W'(1) : '0;
      end else if (cnt_inc) begin
        wr_count_q <= wr_count_q + 1'b1;
      end
      if (rd_valid_q) begin
        rd_data_q <= rd_data;
      end
    end
  end

  // The SPRAM output register is the second read stage: mem_do is presented
  // directly during the rd_valid pulse, then held in rd_data_q afterwards.
  assign rd_data  = rd_valid_q ? (rd_zero_q ? '0 : mem_do) : rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_ack   = (state_q == GNT_WR);
  assign rd_ack   = (state_q == GNT_RD);
  assign mem_ad   = mem_ad_q;
  assign mem_di   = mem_di_q;
  assign mem_we   = mem_we_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_spram_arbiter.sv
module tb_spram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req, wr_count_clr;
  logic [13:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_ack, rd_ack, rd_valid, mem_we;
  logic [15:0] rd_data, mem_di, mem_do;
  logic [13:0] mem_ad, wr_count;

  int checks = 0;
  int errors = 0;

  spram_arbiter #(.ADDR_W(14), .DATA_W(16), .DEPTH_LIMIT(16000), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .mem_ad(mem_ad), .mem_di(mem_di), .mem_we(mem_we),
    .mem_do(mem_do), .wr_count(wr_count), .wr_count_clr(wr_count_clr)
  );

  always #5 clk = ~clk;

  // SPRAM model: registered read, one cycle after the address is sampled.
  logic [15:0] mem [16384];
  always @(posedge clk) begin
    if (mem_we) mem[mem_ad] <= mem_di;
    mem_do <= mem[mem_ad];
  end

  typedef struct {
    logic        wr_req;
    logic [13:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [13:0] rd_addr;
    logic        clr;
    logic        e_wr_ack;
    logic        e_rd_ack;
    logic        e_rd_valid;
    logic        e_mem_we;
    logic [13:0] e_mem_ad;
    logic [15:0] e_mem_di;
    logic [15:0] e_rd_data;
    logic [13:0] e_wr_count;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req = 1'b0; rd_req = 1'b0; wr_count_clr = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic chk_all(input string p, input logic wa, input logic ra, input logic rv,
                         input logic we, input logic [13:0] ad, input logic [15:0] di,
                         input logic [15:0] rdd, input logic [13:0] cnt);
    chk({p, "_wr_ack"},   32'(wr_ack),   32'(wa));
    chk({p, "_rd_ack"},   32'(rd_ack),   32'(ra));
    chk({p, "_rd_valid"}, 32'(rd_valid), 32'(rv));
    chk({p, "_mem_we"},   32'(mem_we),   32'(we));
    chk({p, "_mem_ad"},   32'(mem_ad),   32'(ad));
    chk({p, "_mem_di"},   32'(mem_di),   32'(di));
    chk({p, "_rd_data"},  32'(rd_data),  32'(rdd));
    chk({p, "_wr_count"}, 32'(wr_count), 32'(cnt));
  endtask

  initial begin
    int acks;
    int cyc;
    int seen;

    //        wr  waddr    wdata     rd  raddr    clr  wa rk rv we  mem_ad   mem_di    rd_data   count
    vecs[0]  = '{1, 14'h0005, 16'hABCD, 0, 14'h0000, 0,  1, 0, 0, 1, 14'h0005, 16'hABCD, 16'h0000, 14'd1};
    vecs[1]  = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 0,  0, 0, 0, 0, 14'h0005, 16'hABCD, 16'h0000, 14'd1};
    vecs[2]  = '{1, 14'h0000, 16'h1234, 0, 14'h0000, 0,  1, 0, 0, 1, 14'h0000, 16'h1234, 16'h0000, 14'd2};
    vecs[3]  = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 0,  0, 0, 0, 0, 14'h0000, 16'h1234, 16'h0000, 14'd2};
    vecs[4]  = '{0, 14'h0000, 16'h0000, 1, 14'h0005, 0,  0, 1, 0, 0, 14'h0005, 16'h1234, 16'h0000, 14'd2};
    vecs[5]  = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 0,  0, 0, 1, 0, 14'h0005, 16'h1234, 16'hABCD, 14'd2};
    vecs[6]  = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 0,  0, 0, 0, 0, 14'h0005, 16'h1234, 16'hABCD, 14'd2};
    vecs[7]  = '{1, 14'h0007, 16'h0077, 1, 14'h0000, 0,  0, 1, 0, 0, 14'h0000, 16'h1234, 16'hABCD, 14'd2};
    vecs[8]  = '{1, 14'h0007, 16'h0077, 0, 14'h0000, 0,  1, 0, 1, 1, 14'h0007, 16'h0077, 16'h1234, 14'd3};
    vecs[9]  = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 0,  0, 0, 0, 0, 14'h0007, 16'h0077, 16'h1234, 14'd3};
    vecs[10] = '{1, 14'h3E80, 16'hBEEF, 0, 14'h0000, 0,  1, 0, 0, 0, 14'h3E80, 16'hBEEF, 16'h1234, 14'd3};
    vecs[11] = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 0,  0, 0, 0, 0, 14'h3E80, 16'hBEEF, 16'h1234, 14'd3};
    vecs[12] = '{0, 14'h0000, 16'h0000, 1, 14'h3FFF, 0,  0, 1, 0, 0, 14'h0000, 16'hBEEF, 16'h1234, 14'd3};
    vecs[13] = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 0,  0, 0, 1, 0, 14'h0000, 16'hBEEF, 16'h0000, 14'd3};
    vecs[14] = '{1, 14'h0009, 16'h9999, 1, 14'h0005, 0,  0, 1, 0, 0, 14'h0005, 16'hBEEF, 16'h0000, 14'd3};
    vecs[15] = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 0,  0, 0, 1, 0, 14'h0005, 16'hBEEF, 16'hABCD, 14'd3};
    vecs[16] = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 0,  0, 0, 0, 0, 14'h0005, 16'hBEEF, 16'hABCD, 14'd3};
    vecs[17] = '{0, 14'h0000, 16'h0000, 0, 14'h0000, 1,  0, 0, 0, 0, 14'h0005, 16'hBEEF, 16'hABCD, 14'd0};

    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0, 14'h0, 16'h0, 16'h0, 14'd0);
    rst_n = 1'b1;

    // Directed table: inputs held for one cycle, outputs checked after the edge.
    for (int i = 0; i < 18; i++) begin
      wr_req = vecs[i].wr_req; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      rd_req = vecs[i].rd_req; rd_addr = vecs[i].rd_addr; wr_count_clr = vecs[i].clr;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_wr_ack, vecs[i].e_rd_ack, vecs[i].e_rd_valid,
              vecs[i].e_mem_we, vecs[i].e_mem_ad, vecs[i].e_mem_di, vecs[i].e_rd_data,
              vecs[i].e_wr_count);
    end
    idle_inputs();
    step();

    // Starvation bound: read kept asserted, write must be acked within 6 cycles.
    rd_req = 1'b1; rd_addr = 14'h0005;
    wr_req = 1'b1; wr_addr = 14'h0002; wr_data = 16'h2222;
    seen = 0;
    for (int k = 1; k <= 6 && seen == 0; k++) begin
      step();
      if (wr_ack) begin
        seen = k;
        chk("starve_mem_we", 32'(mem_we), 32'd1);
        chk("starve_mem_ad", 32'(mem_ad), 32'h2);
      end
    end
    chk("starve_ack_within_6", 32'(seen != 0), 32'd1);
    idle_inputs();
    step(); step(); step();

    // Reset in the rd_ack cycle: the read must never complete.
    rd_req = 1'b1; rd_addr = 14'h0005;
    step();
    chk("rstrd_rd_ack", 32'(rd_ack), 32'd1);
    rd_req = 1'b0;
    rst_n = 1'b0;
    step();
    chk_all("rstrd", 0, 0, 0, 0, 14'h0, 16'h0, 16'h0, 14'd0);
    rst_n = 1'b1;
    wr_req = 1'b1; wr_addr = 14'h0003; wr_data = 16'h3333;
    step();
    chk("rel_rd_valid", 32'(rd_valid), 32'd0);
    chk("rel_first_wr_ack", 32'(wr_ack), 32'd1);
    chk("rel_mem_we", 32'(mem_we), 32'd1);
    chk("rel_wr_count", 32'(wr_count), 32'd1);
    wr_req = 1'b0;
    step();
    chk("rel_rd_valid2", 32'(rd_valid), 32'd0);

    // Counter: clear, run to 0x1F3F, clear coinciding with a grant, then wrap.
    wr_count_clr = 1'b1;
    step();
    wr_count_clr = 1'b0;
    chk("clr_only", 32'(wr_count), 32'd0);
    wr_req = 1'b1; wr_addr = 14'h0001; wr_data = 16'h0101;
    acks = 0; cyc = 0;
    while (acks < 8000 - 1 && cyc < 20000) begin
      step();
      cyc++;
      if (wr_ack) acks++;
    end
    chk("cnt_phase1_acks", 32'(acks), 32'd7999);
    chk("cnt_1f3f", 32'(wr_count), 32'h1F3F);
    step();
    chk("cnt_gap_no_ack", 32'(wr_ack), 32'd0);
    wr_count_clr = 1'b1;
    step();
    wr_count_clr = 1'b0;
    chk("clr_with_write_ack", 32'(wr_ack), 32'd1);
    chk("clr_with_write", 32'(wr_count), 32'd1);
    acks = 0; cyc = 0;
    while (acks < 16383 && cyc < 40000) begin
      step();
      cyc++;
      if (wr_ack) acks++;
    end
    chk("cnt_phase2_acks", 32'(acks), 32'd16383);
    chk("cnt_wrap", 32'(wr_count), 32'd0);
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
